ysyx_24110015_sram_arbiter: RTL and testbench

Two-master arbiter that shares the single-port delayed SRAM between the instruction fetch unit (master 0, read-only) and the load/store unit (master 1, read/write). It accepts one request at a time and drives the SRAM's level-held ren/wen strobes until the SRAM answers. It returns the response to the owning master through a valid/ready channel. It sits between IFU/LSU and the SRAM in the NPC memory path.

---
 rtl/ysyx_24110015_sram_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_ysyx_24110015_sram_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_24110015_sram_arbiter.sv
// Two-master arbiter in front of the single-port delayed SRAM.
// Master 0 is instruction fetch (read-only); master 1 is load/store (read/write).
module ysyx_24110015_sram_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    m0_arvalid,
    output logic                    m0_arready,
    input  logic [ADDR_WIDTH-1:0]   m0_araddr,
    output logic                    m0_rvalid,
    input  logic                    m0_rready,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    output logic [1:0]              m0_rresp,

    input  logic                    m1_arvalid,
    output logic                    m1_arready,
    input  logic [ADDR_WIDTH-1:0]   m1_araddr,
    output logic                    m1_rvalid,
    input  logic                    m1_rready,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    output logic [1:0]              m1_rresp,

    input  logic                    m1_awvalid,
    output logic                    m1_awready,
    input  logic [ADDR_WIDTH-1:0]   m1_awaddr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    output logic                    m1_bvalid,
    input  logic                    m1_bready,
    output logic [1:0]              m1_bresp,

    output logic                    s_ren,
    output logic [ADDR_WIDTH-1:0]   s_araddr,
    input  logic                    s_rvalid,
    input  logic [DATA_WIDTH-1:0]   s_rdata,
    input  logic [1:0]              s_rresp,

    output logic                    s_wen,
    output logic [ADDR_WIDTH-1:0]   s_awaddr,
    output logic [DATA_WIDTH-1:0]   s_wdata,
    output logic [DATA_WIDTH/8-1:0] s_wstrb,
    input  logic                    s_bvalid,
    input  logic [1:0]              s_bresp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    state_t state;
    state_t state_next;

    logic cur_master;
    logic cur_op;
    logic last_grant;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH/8-1:0] wstrb_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              resp_q;

    logic m0_req;
    logic m1_req;
    logic grant_m0;
    logic grant_m1;
    logic arb_open;
    logic take_m0;
    logic take_m1_wr;
    logic take_m1_rd;
    logic accept;
    logic sram_done;
    logic owner_ready;

    // Round-robin pick between the masters; inside m1 a write beats a read.
    always_comb begin
        m0_req     = m0_arvalid;
        m1_req     = m1_arvalid | m1_awvalid;
        grant_m0   = m0_req & (~m1_req | last_grant);
        grant_m1   = m1_req & (~m0_req | ~last_grant);
        arb_open   = (state == IDLE) & ~rst;
        take_m0    = arb_open & grant_m0;
        take_m1_wr = arb_open & grant_m1 & m1_awvalid;
        take_m1_rd = arb_open & grant_m1 & ~m1_awvalid & m1_arvalid;
        accept     = take_m0 | take_m1_wr | take_m1_rd;
    end

    // SRAM completion and owner response acceptance for the current transaction.
    always_comb begin
        sram_done   = 1'b0;
        owner_ready = 1'b0;
        if (state == BUSY) begin
            sram_done = (cur_op == OP_WRITE) ? s_bvalid : s_rvalid;
        end
        if (cur_master) begin
            owner_ready = (cur_op == OP_WRITE) ? m1_bready : m1_rready;
        end else begin
            owner_ready = m0_rready;
        end
    end

    // Next-state logic: one request in flight at a time.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (sram_done) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                if (owner_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the winning request and remember who won for the next tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_master <= 1'b0;
            cur_op     <= OP_READ;
            last_grant <= 1'b1;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
        end else if (accept) begin
            cur_master <= ~take_m0;
            cur_op     <= take_m1_wr ? OP_WRITE : OP_READ;
            last_grant <= ~take_m0;
            if (take_m1_wr) begin
                addr_q  <= m1_awaddr;
                wdata_q <= m1_wdata;
                wstrb_q <= m1_wstrb;
            end else begin
                addr_q  <= take_m1_rd ? m1_araddr : m0_araddr;
                wdata_q <= '0;
                wstrb_q <= '0;
            end
        end
    end

    // Capture the SRAM result so it stays stable under response backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            resp_q  <= '0;
        end else if (sram_done) begin
            if (cur_op == OP_WRITE) begin
                resp_q <= s_bresp;
            end else begin
                rdata_q <= s_rdata;
                resp_q  <= s_rresp;
            end
        end
    end

    assign m0_arready = take_m0;
    assign m1_arready = take_m1_rd;
    assign m1_awready = take_m1_wr;

    assign s_ren    = (state == BUSY) & (cur_op == OP_READ);
    assign s_wen    = (state == BUSY) & (cur_op == OP_WRITE);
    assign s_araddr = addr_q;
    assign s_awaddr = addr_q;
    assign s_wdata  = wdata_q;
    assign s_wstrb  = wstrb_q;

    assign m0_rvalid = (state == RESP) & ~cur_master;
    assign m1_rvalid = (state == RESP) & cur_master & (cur_op == OP_READ);
    assign m1_bvalid = (state == RESP) & cur_master & (cur_op == OP_WRITE);

    assign m0_rdata = rdata_q;
    assign m0_rresp = resp_q;
    assign m1_rdata = rdata_q;
    assign m1_rresp = resp_q;
    assign m1_bresp = resp_q;

endmodule

// File: tb/tb_ysyx_24110015_sram_arbiter.sv
// Bench for the IFU/LSU SRAM arbiter: delayed SRAM model, master agents,
// transaction-level reference model checked every cycle, directed tests.
module tb_ysyx_24110015_sram_arbiter;

    localparam int D = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        m0_arvalid = 1'b0;
    logic        m0_arready;
    logic [31:0] m0_araddr = '0;
    logic        m0_rvalid;
    logic        m0_rready = 1'b1;
    logic [31:0] m0_rdata;
    logic [1:0]  m0_rresp;

    logic        m1_arvalid = 1'b0;
    logic        m1_arready;
    logic [31:0] m1_araddr = '0;
    logic        m1_rvalid;
    logic        m1_rready = 1'b1;
    logic [31:0] m1_rdata;
    logic [1:0]  m1_rresp;

    logic        m1_awvalid = 1'b0;
    logic        m1_awready;
    logic [31:0] m1_awaddr = '0;
    logic [31:0] m1_wdata = '0;
    logic [3:0]  m1_wstrb = '0;
    logic        m1_bvalid;
    logic        m1_bready = 1'b1;
    logic [1:0]  m1_bresp;

    logic        s_ren;
    logic [31:0] s_araddr;
    logic        s_rvalid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_wen;
    logic [31:0] s_awaddr;
    logic [31:0] s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_bvalid;
    logic [1:0]  s_bresp;

    ysyx_24110015_sram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr),
        .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
        .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
        .s_ren(s_ren), .s_araddr(s_araddr), .s_rvalid(s_rvalid),
        .s_rdata(s_rdata), .s_rresp(s_rresp),
        .s_wen(s_wen), .s_awaddr(s_awaddr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bresp(s_bresp)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, {m0_arready, m1_arready, m1_awready, m0_rvalid,
                           m1_rvalid, m1_bvalid, s_ren, s_wen}, 0);
        chk({nm, "_saddr"}, {s_araddr, s_awaddr}, 0);
        chk({nm, "_swdata"}, {s_wdata, s_wstrb, m1_bresp}, 0);
        chk({nm, "_rdata"}, {m0_rdata, m1_rdata}, 0);
        chk({nm, "_rresp"}, {m0_rresp, m1_rresp}, 0);
    endtask

    function automatic logic [31:0] mask_of(input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            if (s[b]) m[8*b +: 8] = 8'hFF;
        end
        return m;
    endfunction

    // Delayed SRAM: result appears after the strobe has been held D cycles.
    logic [31:0] smem [0:63];
    logic [31:0] ref_mem [0:63];
    int scnt = 0;

    assign s_rvalid = s_ren && (scnt == D);
    assign s_rdata  = smem[s_araddr[7:2]];
    assign s_rresp  = s_araddr[5:4];
    assign s_bvalid = s_wen && (scnt == D);
    assign s_bresp  = s_awaddr[5:4];

    always @(posedge clk) begin
        cyc = cyc + 1;
    end

    always @(posedge clk) begin
        if (s_ren || s_wen) scnt <= scnt + 1;
        else scnt <= 0;
        if (s_wen && scnt == D) begin
            for (int b = 0; b < 4; b++) begin
                if (s_wstrb[b]) smem[s_awaddr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
            end
        end
    end

    // Master agents: queued requests, each held until its handshake.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } wreq_t;

    logic [31:0] q0[$];
    logic [31:0] q1r[$];
    wreq_t qw[$];
    bit hs0 = 0, hs1r = 0, hs1w = 0;
    int n_hs0 = 0, n_rsp0 = 0, n_rsp1 = 0, n_b = 0;
    logic [31:0] last_rdata0, last_rdata1;
    logic [1:0] last_rresp0, last_rresp1, last_bresp;

    always @(negedge clk) begin
        if (m0_arvalid && m0_arready) begin hs0 = 1; n_hs0++; end
        if (m1_arvalid && m1_arready) hs1r = 1;
        if (m1_awvalid && m1_awready) hs1w = 1;
        if (m0_rvalid && m0_rready) begin
            n_rsp0++; last_rdata0 = m0_rdata; last_rresp0 = m0_rresp;
        end
        if (m1_rvalid && m1_rready) begin
            n_rsp1++; last_rdata1 = m1_rdata; last_rresp1 = m1_rresp;
        end
        if (m1_bvalid && m1_bready) begin
            n_b++; last_bresp = m1_bresp;
        end
    end

    always @(posedge clk) begin
        wreq_t w;
        #1;
        if (hs0) begin void'(q0.pop_front()); hs0 = 0; end
        if (hs1r) begin void'(q1r.pop_front()); hs1r = 0; end
        if (hs1w) begin void'(qw.pop_front()); hs1w = 0; end
        m0_arvalid = (q0.size() != 0);
        m0_araddr  = m0_arvalid ? q0[0] : '0;
        m1_arvalid = (q1r.size() != 0);
        m1_araddr  = m1_arvalid ? q1r[0] : '0;
        m1_awvalid = (qw.size() != 0);
        w = m1_awvalid ? qw[0] : '0;
        m1_awaddr = w.addr;
        m1_wdata  = w.data;
        m1_wstrb  = w.strb;
    end

    // Direct measurements for the literal latency expectations.
    int hs0_cyc = 0, lat0 = -1, ren_run = 0, ren_len = 0, wen_run = 0, wen_len = 0;
    bit rv0_prev = 0;

    always @(negedge clk) begin
        if (m0_arvalid && m0_arready) hs0_cyc = cyc;
        if (m0_rvalid && !rv0_prev) lat0 = cyc - hs0_cyc;
        rv0_prev = m0_rvalid;
        if (s_ren) ren_run++;
        else if (ren_run != 0) begin ren_len = ren_run; ren_run = 0; end
        if (s_wen) wen_run++;
        else if (wen_run != 0) begin wen_len = wen_run; wen_run = 0; end
    end

    // Transaction-level reference model compared every cycle.
    bit m_busy = 0;
    int m_last = 1;
    int m_master = 0;
    bit m_op = 0;
    logic [31:0] m_addr, m_wdata, m_exp;
    logic [3:0] m_wstrb;
    int m_start = 0;
    int glog[$];
    int gop[$];

    always @(negedge clk) begin
        int w, k;
        bit stb, rsp, rdy;
        logic [5:0] ix;
        if (rst) begin
            m_busy = 0;
            m_last = 1;
            chk_zero("in_rst");
        end else if (!m_busy) begin
            if (m0_arvalid && (m1_arvalid || m1_awvalid)) w = (m_last == 0) ? 1 : 0;
            else if (m0_arvalid) w = 0;
            else if (m1_arvalid || m1_awvalid) w = 1;
            else w = -1;
            chk("idle_m0_arready", m0_arready, w == 0);
            chk("idle_m1_awready", m1_awready, w == 1 && m1_awvalid);
            chk("idle_m1_arready", m1_arready, w == 1 && !m1_awvalid);
            chk("idle_strobes", {s_ren, s_wen}, 0);
            chk("idle_valids", {m0_rvalid, m1_rvalid, m1_bvalid}, 0);
            if (w >= 0) begin
                m_master = w;
                m_op = (w == 1) && m1_awvalid;
                m_addr = (w == 0) ? m0_araddr : (m_op ? m1_awaddr : m1_araddr);
                m_wdata = m1_wdata;
                m_wstrb = m1_wstrb;
                ix = m_addr[7:2];
                if (m_op) begin
                    ref_mem[ix] = (ref_mem[ix] & ~mask_of(m_wstrb)) |
                                  (m_wdata & mask_of(m_wstrb));
                end
                m_exp = ref_mem[ix];
                m_start = cyc;
                m_last = w;
                m_busy = 1;
                glog.push_back(w);
                gop.push_back(int'(m_op));
            end
        end else begin
            k = cyc - m_start;
            stb = (k >= 1) && (k <= D + 1);
            rsp = (k >= D + 2);
            chk("excl_strobes", s_ren && s_wen, 0);
            chk("busy_readies", {m0_arready, m1_arready, m1_awready}, 0);
            chk("s_ren", s_ren, stb && !m_op);
            chk("s_wen", s_wen, stb && m_op);
            if (stb && m_op) begin
                chk("s_wpayload", {s_awaddr, s_wdata}, {m_addr, m_wdata});
                chk("s_wstrb", s_wstrb, m_wstrb);
            end
            if (stb && !m_op) chk("s_araddr", s_araddr, m_addr);
            chk("m0_rvalid", m0_rvalid, rsp && m_master == 0);
            chk("m1_rvalid", m1_rvalid, rsp && m_master == 1 && !m_op);
            chk("m1_bvalid", m1_bvalid, rsp && m_master == 1 && m_op);
            if (rsp) begin
                if (m_master == 0) begin
                    chk("m0_rdata", {m0_rresp, m0_rdata}, {m_addr[5:4], m_exp});
                    rdy = m0_rready;
                end else if (!m_op) begin
                    chk("m1_rdata", {m1_rresp, m1_rdata}, {m_addr[5:4], m_exp});
                    rdy = m1_rready;
                end else begin
                    chk("m1_bresp", m1_bresp, m_addr[5:4]);
                    rdy = m1_bready;
                end
                if (rdy) m_busy = 0;
            end
        end
    end

    task automatic wait_rsp(input int t0, input int t1, input int tb, input string nm);
        int i;
        i = 0;
        while ((n_rsp0 < t0 || n_rsp1 < t1 || n_b < tb) && i < 2000) begin
            @(posedge clk);
            i++;
        end
        chk({nm, "_timeout"}, i >= 2000, 0);
        @(posedge clk);
    endtask

    task automatic pulse_rst();
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    initial begin
        int b0, b1, bb, gb, i;
        for (int j = 0; j < 64; j++) begin
            smem[j] = 32'hA5A5_0000 | j;
            ref_mem[j] = 32'hA5A5_0000 | j;
        end
        smem[0] = 32'hDEAD_BEEF;
        ref_mem[0] = 32'hDEAD_BEEF;
        smem[4] = 32'hAAAA_AAAA;
        ref_mem[4] = 32'hAAAA_AAAA;

        #2 chk_zero("reset_state");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // lone m0 read
        q0.push_back(32'h8000_0000);
        wait_rsp(1, 0, 0, "m0_read");
        chk("t1_rdata", last_rdata0, 32'hDEAD_BEEF);
        chk("t1_rresp", last_rresp0, 0);
        chk("t1_latency", lat0, 12);
        chk("t1_ren_len", ren_len, 11);

        // byte-masked m1 write, then read back
        qw.push_back('{32'h8000_0010, 32'h1234_5678, 4'b0011});
        wait_rsp(1, 0, 1, "m1_write");
        chk("t2_bcount", n_b, 1);
        chk("t2_bresp", last_bresp, 2'd1);
        chk("t2_wen_len", wen_len, 11);
        chk("t2_mem", smem[4], 32'hAAAA_5678);
        q1r.push_back(32'h8000_0010);
        wait_rsp(1, 1, 1, "m1_readback");
        chk("t2_rdata", last_rdata1, 32'hAAAA_5678);
        chk("t2_rresp", last_rresp1, 2'd1);

        // contention from reset: 8 transactions alternate starting with m0
        pulse_rst();
        b0 = n_rsp0; b1 = n_rsp1; gb = glog.size();
        for (int j = 0; j < 4; j++) begin
            q0.push_back(32'h8000_0040 + 4 * j);
            q1r.push_back(32'h8000_0050 + 4 * j);
        end
        wait_rsp(b0 + 4, b1 + 4, n_b, "contend");
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("t3_grant%0d", j), glog[gb + j], j % 2);
        end
        chk("t3_last_m1", last_rdata1, 32'hA5A5_0017);

        // m1 write and read together: write first, read sees it
        b1 = n_rsp1; bb = n_b; gb = glog.size();
        qw.push_back('{32'h8000_0020, 32'hCAFE_F00D, 4'b1111});
        q1r.push_back(32'h8000_0020);
        wait_rsp(n_rsp0, b1 + 1, bb + 1, "m1_wr_rd");
        chk("t4_first_op", gop[gb], 1);
        chk("t4_second_op", gop[gb + 1], 0);
        chk("t4_rdata", last_rdata1, 32'hCAFE_F00D);
        chk("t4_bresp", last_bresp, 2'd2);

        // response backpressure on m0 with m1 waiting
        m0_rready = 1'b0;
        b0 = n_rsp0; b1 = n_rsp1; gb = glog.size();
        i = n_hs0;
        q0.push_back(32'h8000_0000);
        for (int j = 0; j < 50 && n_hs0 == i; j++) @(negedge clk);
        chk("t5_hs_seen", n_hs0, i + 1);
        q1r.push_back(32'h8000_0008);
        i = 0;
        while (!m0_rvalid && i < 50) begin @(negedge clk); i++; end
        chk("t5_rvalid_timeout", i >= 50, 0);
        for (int j = 0; j < 5; j++) begin
            chk("t5_hold_rvalid", m0_rvalid, 1);
            chk("t5_hold_rdata", m0_rdata, 32'hDEAD_BEEF);
            chk("t5_hold_noren", {s_ren, m1_arready}, 0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 m0_rready = 1'b1;
        wait_rsp(b0 + 1, b1 + 1, n_b, "backpressure");
        chk("t5_order", {glog[gb], glog[gb + 1]}, {32'd0, 32'd1});
        chk("t5_m1_rdata", last_rdata1, 32'hA5A5_0002);

        // reset while BUSY, then a fresh read
        b0 = n_rsp0;
        q0.push_back(32'h8000_0004);
        i = 0;
        while (!s_ren && i < 50) begin @(negedge clk); i++; end
        chk("t6_ren_timeout", i >= 50, 0);
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1 chk_zero("t6_async");
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        chk("t6_no_resp", n_rsp0, b0);
        q0.push_back(32'h8000_0004);
        wait_rsp(b0 + 1, n_rsp1, n_b, "after_rst");
        chk("t6_latency", lat0, 12);
        chk("t6_rdata", last_rdata0, 32'hA5A5_0001);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout actual=%0d required=done", cyc);
        $fatal(1, "timeout");
    end

endmodule
